io_uart_tx: RTL and testbench
=============================

Name: io_uart_tx

Overview:
- Downstream consumer of the CPU's `io_write`/`io_data` output port.
- Captures each 32-bit word the CPU writes and queues it in a small FIFO.
- Sends each word over a UART 8N1 serial line as 8 lowercase hex ASCII characters followed by a line feed.
- This is the hardware equivalent of the simulation console print, so CPU output is observable on silicon.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit (must be ≥2).
- FIFO_DEPTH, 8, number of queued words (power of two, ≥2).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous active-high reset.
- io_write  input  1  CPU write strobe; a write is its rising edge.
- io_data  input  32  CPU write data; valid in the cycle io_write rises.
- uart_tx  output  1  serial line; idles high.
- busy  output  1  high while FIFO non-empty or a word is being sent.
- fifo_full  output  1  FIFO holds FIFO_DEPTH words.
- drop_cnt  output  8  count of writes lost to a full FIFO; saturates at 255.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: uart_tx=1, busy=0, fifo_full=0, drop_cnt=0, FIFO empty, formatter in IDLE, io_write history register=0.
- Reset mid-frame: the line goes high immediately and all queued words are discarded.
- Edge detect:
  - io_write_q <= io_write each cycle.
  - push = io_write & ~io_write_q.
  - io_data is sampled in the push cycle.
  - Holding io_write high for many cycles gives exactly one push.
- FIFO:
  - Synchronous write and read pointers, one bit wider than log2(FIFO_DEPTH) to tell full from empty.
  - Pop happens when the formatter is in IDLE and the FIFO is non-empty.
  - Push and pop in the same cycle while full: both take effect, no drop.
  - Push while full without a same-cycle pop: word discarded, drop_cnt increments (saturating).
  - Push and pop in the same cycle while empty cannot occur: pop needs the word to be present in the prior cycle.
- Formatter states:
  - IDLE: on pop, latch the word and set char_idx=0, then go to SEND.
  - SEND: char_idx 0..7 selects nibble [31-4*idx -: 4], MSB first, mapped to 0x30..0x39 or 0x61..0x66. char_idx 8 sends 0x0A.
  - In SEND, offer the byte to the serializer with valid. On accept (valid & ready), increment char_idx. After char_idx 8 is accepted, return to IDLE.
- Serializer (valid/ready):
  - ready=1 only in its IDLE state.
  - On accept: start bit 0, then data bits 0..7 LSB first, then stop bit 1. Each bit is held exactly CLKS_PER_BIT cycles.
  - ready returns high in the last cycle of the stop bit, so back-to-back bytes have no idle gap.
  - A frame is 10*CLKS_PER_BIT cycles; a full word is 90*CLKS_PER_BIT cycles.
- Latency:
  - Push in cycle N with the block idle: pop in N+1, byte offered in N+2.
  - Start bit appears on uart_tx from cycle N+3.
- busy is combinational: FIFO non-empty | formatter not IDLE | serializer not IDLE.

Decomposition:
- Shared package `io_uart_pkg`:
  - formatter and serializer state enums.
  - ASCII constants: ASCII_0=0x30, ASCII_A_LC=0x61, ASCII_LF=0x0A.
  - CHARS_PER_WORD=9.
  - nibble-to-ASCII function.
- One sub-module: `uart_tx_byte`, the 8N1 serializer with valid/ready, parameterised by CLKS_PER_BIT.
- FIFO and formatter stay in the top level.

Test Plan:
- Reset values: assert rst mid-run (asynchronously) -> uart_tx=1, busy=0, drop_cnt=0 within the same cycle, without waiting for a clock edge.
- Single word, CLKS_PER_BIT=4:
  - Stimulus: pulse io_write with io_data=0x0000002A.
  - Required: decoded bytes 0x30×6, 0x32, 0x61, 0x0A.
  - Required: start bit begins 3 cycles after the push cycle.
  - Required: busy drops 360 cycles after the start bit begins.
- Held strobe: io_write high for 50 cycles with data 0xDEADBEEF -> exactly one word, "deadbeef\n".
- Overflow, FIFO_DEPTH=8:
  - Stimulus: 11 edges 2 cycles apart, data 1..11.
  - Required: drop_cnt=2, fifo_full=1 after edge 9.
  - Required: output words 1..9 in order; 10 and 11 absent.
- Full push/pop coincidence: FIFO full, and a push lands in the pop cycle -> pushed word is transmitted, drop_cnt unchanged.
- Reset mid-frame: rst during the data bits of character 3 -> uart_tx=1 immediately; after release, the next write produces a clean full frame sequence.

Source files
------------

// File: rtl/io_uart_pkg.sv
// Shared types, constants and helpers for the io_uart_tx console block.
// Holds the formatter/serializer state enums, ASCII constants and the
// nibble-to-hex-character mapping used when printing CPU output words.
package io_uart_pkg;

  typedef enum logic {
    FMT_IDLE,
    FMT_SEND
  } fmt_state_e;

  typedef enum logic [1:0] {
    SER_IDLE,
    SER_START,
    SER_DATA,
    SER_STOP
  } ser_state_e;

  localparam logic [7:0] ASCII_0    = 8'h30;
  localparam logic [7:0] ASCII_A_LC = 8'h61;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  // Eight hex digits plus the trailing line feed.
  localparam int         CHARS_PER_WORD = 9;
  localparam logic [3:0] LAST_CHAR_IDX  = 4'(CHARS_PER_WORD - 1);

  // 0..9 -> '0'..'9', 10..15 -> 'a'..'f'
  function automatic logic [7:0] nib2ascii(input logic [3:0] nib);
    logic [7:0] ch;
    if (nib < 4'd10) begin
      ch = ASCII_0 + {4'd0, nib};
    end else begin
      ch = ASCII_A_LC + {4'd0, nib} - 8'd10;
    end
    return ch;
  endfunction

endpackage

// File: rtl/io_uart_tx_byte.sv
// uart_tx_byte: 8N1 serializer with a valid/ready byte input.
// Ports: clk_i/rst_i (async active-high), valid_i/data_i/ready_o byte
// handshake, tx_o serial line (idles high), busy_o (not in IDLE).
module uart_tx_byte
  import io_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       valid_i,
  input  logic [7:0] data_i,
  output logic       ready_o,
  output logic       tx_o,
  output logic       busy_o
);

  localparam int            CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  ser_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          bit_end;

  assign bit_end = (cnt_q == CNT_LAST);
  assign busy_o  = (state_q != SER_IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= SER_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    ready_o = 1'b0;
    tx_o    = 1'b1;
    case (state_q)
      SER_IDLE: begin
        ready_o = 1'b1;
        if (valid_i) begin
          state_d = SER_START;
          cnt_d   = '0;
          shreg_d = data_i;
        end
      end
      SER_START: begin
        tx_o = 1'b0;
        if (bit_end) begin
          state_d = SER_DATA;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SER_DATA: begin
        tx_o = shreg_q[0];
        if (bit_end) begin
          cnt_d   = '0;
          shreg_d = shreg_q >> 1;
          if (bit_q == 3'd7) begin
            state_d = SER_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SER_STOP: begin
        tx_o = 1'b1;
        if (bit_end) begin
          // Accept the next byte in the final stop cycle so consecutive
          // frames abut with no idle gap.
          ready_o = 1'b1;
          cnt_d   = '0;
          if (valid_i) begin
            state_d = SER_START;
            shreg_d = data_i;
          end else begin
            state_d = SER_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = SER_IDLE;
    endcase
  end

endmodule

// File: rtl/io_uart_tx.sv
// io_uart_tx: prints each CPU io_write word on a UART line as 8 lowercase
// hex characters plus LF. Ports: clk/rst (async active-high), io_write/
// io_data CPU port, uart_tx serial out, busy, fifo_full, drop_cnt (sat. 255).
module io_uart_tx
  import io_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        io_write,
  input  logic [31:0] io_data,
  output logic        uart_tx,
  output logic        busy,
  output logic        fifo_full,
  output logic [7:0]  drop_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);

  // Strobe edge detect: a held strobe yields one push.
  logic io_write_q;
  logic push;

  assign push = io_write & ~io_write_q;

  // Word FIFO; pointers carry one extra wrap bit to tell full from empty.
  logic [31:0] mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        fifo_empty;
  logic        pop;
  logic        push_ok;
  logic        drop;
  logic [7:0]  drop_cnt_q;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // A pop frees a slot in the same cycle, so a push into a full FIFO that
  // coincides with a pop is kept.
  assign push_ok    = push & (~fifo_full | pop);
  assign drop       = push & fifo_full & ~pop;
  assign drop_cnt   = drop_cnt_q;

  // Formatter
  fmt_state_e  fmt_state_q, fmt_state_d;
  logic [3:0]  char_idx_q, char_idx_d;
  logic [31:0] word_q, word_d;
  logic [4:0]  nib_lsb;
  logic        ser_valid;
  logic        ser_ready;
  logic        ser_busy;
  logic [7:0]  ser_data;

  assign pop = (fmt_state_q == FMT_IDLE) & ~fifo_empty;

  // Character idx 0..7 picks nibble 7-idx (MSB first); for 3 bits 7-idx == ~idx.
  assign nib_lsb  = {~char_idx_q[2:0], 2'b00};
  assign ser_data = (char_idx_q == LAST_CHAR_IDX) ? ASCII_LF
                                                  : nib2ascii(word_q[nib_lsb +: 4]);

  assign busy = ~fifo_empty | (fmt_state_q != FMT_IDLE) | ser_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      io_write_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      drop_cnt_q  <= '0;
      fmt_state_q <= FMT_IDLE;
      char_idx_q  <= '0;
      word_q      <= '0;
    end else begin
      io_write_q <= io_write;
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      if (drop && (drop_cnt_q != 8'hFF)) drop_cnt_q <= drop_cnt_q + 1'b1;
      fmt_state_q <= fmt_state_d;
      char_idx_q  <= char_idx_d;
      word_q      <= word_d;
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= io_data;
  end

  always_comb begin
    fmt_state_d = fmt_state_q;
    char_idx_d  = char_idx_q;
    word_d      = word_q;
    ser_valid   = 1'b0;
    case (fmt_state_q)
      FMT_IDLE: begin
        if (pop) begin
          word_d      = mem_q[rd_ptr_q[AW-1:0]];
          char_idx_d  = '0;
          fmt_state_d = FMT_SEND;
        end
      end
      FMT_SEND: begin
        ser_valid = 1'b1;
        if (ser_ready) begin
          if (char_idx_q == LAST_CHAR_IDX) begin
            fmt_state_d = FMT_IDLE;
          end else begin
            char_idx_d = char_idx_q + 1'b1;
          end
        end
      end
      default: fmt_state_d = FMT_IDLE;
    endcase
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_ser (
    .clk_i  (clk),
    .rst_i  (rst),
    .valid_i(ser_valid),
    .data_i (ser_data),
    .ready_o(ser_ready),
    .tx_o   (uart_tx),
    .busy_o (ser_busy)
  );

endmodule

// File: tb/tb_io_uart_tx.sv
// Bench for io_uart_tx: drives CPU writes, decodes the UART line and
// compares every received byte against an expected-byte queue, plus
// timing, flag and reset checks.
`timescale 1ns/1ps
module tb_io_uart_tx;

  localparam int C = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        io_write = 1'b0;
  logic [31:0] io_data = '0;
  logic        uart_tx;
  logic        busy;
  logic        fifo_full;
  logic [7:0]  drop_cnt;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];

  io_uart_tx #(
    .CLKS_PER_BIT(C),
    .FIFO_DEPTH  (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .io_write (io_write),
    .io_data  (io_data),
    .uart_tx  (uart_tx),
    .busy     (busy),
    .fifo_full(fifo_full),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, expv);
    end
  endtask

  // Step to n posedges later, then 1ns past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected characters of one word: 8 lowercase hex digits, MSB first, then LF.
  task automatic expect_word(input logic [31:0] w);
    logic [3:0] nib;
    for (int i = 0; i < 8; i++) begin
      nib = 4'(w >> (28 - 4 * i));
      if (nib < 4'd10) exp_q.push_back(8'h30 + {4'h0, nib});
      else             exp_q.push_back(8'h57 + {4'h0, nib});
    end
    exp_q.push_back(8'h0A);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      tick(1);
      n++;
    end
    check("idle_within_budget", {31'd0, busy}, 32'd0);
  endtask

  // UART receiver / scoreboard monitor: samples at bit centres on negedges.
  initial begin : rx_mon
    int         cnt;
    int         j;
    logic       act;
    logic [7:0] sh;
    logic [7:0] expb;
    act = 1'b0;
    cnt = 0;
    sh  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        act = 1'b0;
      end else if (!act) begin
        if (uart_tx === 1'b0) begin
          act = 1'b1;
          cnt = 0;
        end
      end else begin
        cnt++;
        if ((cnt % C) == (C / 2)) begin
          j = cnt / C;
          if (j == 0) begin
            check("rx_start_bit", {31'd0, uart_tx}, 32'd0);
          end else if (j <= 8) begin
            sh[j-1] = uart_tx;
          end else begin
            check("rx_stop_bit", {31'd0, uart_tx}, 32'd1);
            act = 1'b0;
            if (exp_q.size() == 0) begin
              tests++;
              fails++;
              $display("FAIL rx_unexpected_byte: got %0h, required no byte", sh);
            end else begin
              expb = exp_q.pop_front();
              check("rx_byte", {24'd0, sh}, {24'd0, expb});
            end
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset values ----------------
    #1 rst = 1'b1;
    #2;
    check("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_fifo_full", {31'd0, fifo_full}, 32'd0);
    check("rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
    tick(3);
    rst = 1'b0;
    tick(2);

    // ---------------- single word 0x2A, latency ----------------
    io_write = 1'b1;
    io_data  = 32'h0000_002A;
    for (int i = 0; i < 6; i++) exp_q.push_back(8'h30);
    exp_q.push_back(8'h32);
    exp_q.push_back(8'h61);
    exp_q.push_back(8'h0A);
    tick(1);
    io_write = 1'b0;
    check("busy_after_push", {31'd0, busy}, 32'd1);
    tick(1);
    check("line_idle_n2", {31'd0, uart_tx}, 32'd1);
    tick(1);
    check("start_bit_n3", {31'd0, uart_tx}, 32'd0);
    tick(359);
    check("busy_at_start_plus_359", {31'd0, busy}, 32'd1);
    tick(1);
    check("busy_drop_start_plus_360", {31'd0, busy}, 32'd0);
    check("drain_single", exp_q.size(), 32'd0);

    // ---------------- held strobe ----------------
    tick(2);
    io_write = 1'b1;
    io_data  = 32'hDEAD_BEEF;
    begin
      string s;
      s = "deadbeef";
      for (int i = 0; i < 8; i++) exp_q.push_back(s[i]);
      exp_q.push_back(8'h0A);
    end
    tick(50);
    io_write = 1'b0;
    wait_idle(2000);
    check("drain_held", exp_q.size(), 32'd0);

    // ---------------- overflow ----------------
    tick(2);
    for (int i = 1; i <= 11; i++) begin
      io_write = 1'b1;
      io_data  = i;
      if (i <= 9) expect_word(i);
      tick(1);
      io_write = 1'b0;
      if (i == 8)  check("ovf_not_full_after_8", {31'd0, fifo_full}, 32'd0);
      if (i == 9)  check("ovf_full_after_9", {31'd0, fifo_full}, 32'd1);
      if (i == 10) check("ovf_drop_after_10", {24'd0, drop_cnt}, 32'd1);
      tick(1);
    end
    check("ovf_drop_cnt", {24'd0, drop_cnt}, 32'd2);
    check("ovf_still_full", {31'd0, fifo_full}, 32'd1);
    wait_idle(9 * 90 * C + 200);
    check("drain_overflow", exp_q.size(), 32'd0);
    check("ovf_drop_cnt_final", {24'd0, drop_cnt}, 32'd2);

    // ---------------- reset mid-frame ----------------
    tick(2);
    io_write = 1'b1;
    io_data  = 32'h1234_5678;
    expect_word(32'h1234_5678);
    tick(1);
    io_write = 1'b0;
    tick(1);
    io_write = 1'b1;
    io_data  = 32'hCAFE_0001;      // queued, must be discarded by reset
    tick(1);
    io_write = 1'b0;
    tick(137);                     // 4th char '4' (0x34), data bit 3 = 0
    check("pre_reset_line_low", {31'd0, uart_tx}, 32'd0);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_uart_tx", {31'd0, uart_tx}, 32'd1);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
    check("mid_rst_fifo_full", {31'd0, fifo_full}, 32'd0);
    check("mid_rst_chars_seen", exp_q.size(), 32'd6);
    exp_q.delete();
    tick(2);
    rst = 1'b0;
    tick(2);
    io_write = 1'b1;
    io_data  = 32'h0F1E_2D3C;
    expect_word(32'h0F1E_2D3C);
    tick(1);
    io_write = 1'b0;
    wait_idle(2000);
    check("drain_after_reset", exp_q.size(), 32'd0);

    // ---------------- full FIFO, push in the pop cycle ----------------
    tick(2);
    io_write = 1'b1;
    io_data  = 32'hA000_0000;
    expect_word(32'hA000_0000);
    for (int j = 1; j <= 8; j++) begin
      tick(1);
      io_write = 1'b0;
      tick(1);
      io_write = 1'b1;
      io_data  = 32'hA000_0000 + j;
      expect_word(32'hA000_0000 + j);
    end
    tick(1);
    io_write = 1'b0;
    check("co_full_before", {31'd0, fifo_full}, 32'd1);
    tick(305);
    check("co_full_pre_pop", {31'd0, fifo_full}, 32'd1);
    tick(1);                       // pop cycle: start + 80*C
    io_write = 1'b1;
    io_data  = 32'hB000_00C0;
    expect_word(32'hB000_00C0);
    tick(1);
    io_write = 1'b0;
    check("co_full_after", {31'd0, fifo_full}, 32'd1);
    check("co_no_drop", {24'd0, drop_cnt}, 32'd0);
    wait_idle(10 * 90 * C + 200);
    check("drain_coincide", exp_q.size(), 32'd0);
    check("co_drop_final", {24'd0, drop_cnt}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
